// File: rtl/axis_pixel_framer.sv
// axis_pixel_framer: forces every ingress frame to exactly FRAME_LEN beats.
// Ports: clock/reset, s_axis_* ingress, m_axis_* egress, err/frame status.
module axis_pixel_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 784,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  err_clr,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    STREAM,
    PAD,
    DROP
  } state_t;

  state_t                state;
  logic                  run;
  logic [CW-1:0]         in_cnt;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  beat;
  logic                  at_last;
  logic                  set_short;
  logic                  set_long;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH:0]   head;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign at_last = in_cnt == LAST_IDX;

  // run holds ready low until the first clock after reset is released.
  // Ready is built only from registers, so m_axis_tready never reaches it.
  always_comb begin
    s_axis_tready = 1'b0;
    wr_data       = '0;
    unique case (state)
      STREAM: begin
        s_axis_tready = run && !full;
        wr_data       = s_axis_tdata;
      end
      DROP:    s_axis_tready = run;
      default: ;
    endcase
  end

  assign beat = s_axis_tvalid && s_axis_tready;
  assign push = (state == STREAM) ? beat :
                ((state == PAD) && run && !full);
  assign pop  = !empty && m_axis_tready;

  assign set_short = (state == STREAM) && beat &&
                     s_axis_tlast && !at_last;
  assign set_long  = (state == STREAM) && beat &&
                     !s_axis_tlast && at_last;

  // Head entry is gated so idle/reset egress reads as zero.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !empty && head[DATA_WIDTH];

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {at_last, wr_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= STREAM;
      run         <= 1'b0;
      in_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      run <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      frame_done <= pop && head[DATA_WIDTH];
      if (pop && head[DATA_WIDTH])
        frame_count <= frame_count + 16'd1;
      // A new error in the clear cycle still sets the bit.
      err_short <= set_short | (err_short & ~err_clr);
      err_long  <= set_long | (err_long & ~err_clr);
      unique case (state)
        STREAM: begin
          if (beat) begin
            if (at_last) begin
              in_cnt <= '0;
              if (!s_axis_tlast)
                state <= DROP;
            end else begin
              in_cnt <= in_cnt + 1'b1;
              if (s_axis_tlast)
                state <= PAD;
            end
          end
        end
        PAD: begin
          if (push) begin
            if (at_last) begin
              in_cnt <= '0;
              state  <= STREAM;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (beat && s_axis_tlast)
            state <= STREAM;
        end
        default: state <= STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pixel_framer.sv
// tb_axis_pixel_framer: directed bench for a 784-beat and an 8-beat framer.
// Shared ingress bus, sel picks which instance sees tvalid.
module tb_axis_pixel_framer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        rst_s;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        sel;

  logic        b_tvalid;
  logic        b_sready;
  logic [15:0] b_mdata;
  logic        b_mvalid;
  logic        b_mlast;
  logic        b_mready = 1'b1;
  logic        b_clr;
  logic        b_es;
  logic        b_el;
  logic        b_done;
  logic [15:0] b_cnt;

  logic        s_tvalid;
  logic        s_sready;
  logic [15:0] s_mdata;
  logic        s_mvalid;
  logic        s_mlast;
  logic        s_mready = 1'b1;
  logic        s_clr;
  logic        s_es;
  logic        s_el;
  logic        s_done;
  logic [15:0] s_cnt;

  assign b_tvalid = tvalid && !sel;
  assign s_tvalid = tvalid && sel;

  axis_pixel_framer #(
    .DATA_WIDTH(16), .FRAME_LEN(784), .FIFO_DEPTH(16)
  ) u_big (
    .clock(clk), .reset(rst_b),
    .s_axis_tdata(tdata), .s_axis_tvalid(b_tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(b_sready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
    .m_axis_tlast(b_mlast), .m_axis_tready(b_mready),
    .err_clr(b_clr), .err_short(b_es), .err_long(b_el),
    .frame_done(b_done), .frame_count(b_cnt)
  );

  axis_pixel_framer #(
    .DATA_WIDTH(16), .FRAME_LEN(8), .FIFO_DEPTH(16)
  ) u_small (
    .clock(clk), .reset(rst_s),
    .s_axis_tdata(tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(s_sready),
    .m_axis_tdata(s_mdata), .m_axis_tvalid(s_mvalid),
    .m_axis_tlast(s_mlast), .m_axis_tready(s_mready),
    .err_clr(s_clr), .err_short(s_es), .err_long(s_el),
    .frame_done(s_done), .frame_count(s_cnt)
  );

  // egress pattern for the big instance: 0 ready, 1 toggle, 2 stall
  int bp = 0;
  always @(posedge clk) begin
    #1;
    case (bp)
      0:       b_mready = 1'b1;
      1:       b_mready = !b_mready;
      default: b_mready = 1'b0;
    endcase
  end

  logic [16:0] qb[$];
  logic [16:0] qs[$];
  int          done_b = 0;
  int          viol = 0;
  logic        stall_b = 1'b0;
  logic [16:0] prev_b = '0;

  always @(negedge clk) begin
    if (b_mvalid && b_mready) qb.push_back({b_mlast, b_mdata});
    if (s_mvalid && s_mready) qs.push_back({s_mlast, s_mdata});
    if (b_done) done_b <= done_b + 1;
    if (b_mvalid && !b_mready) begin
      if (stall_b && {b_mlast, b_mdata} != prev_b) viol <= viol + 1;
      stall_b <= 1'b1;
      prev_b  <= {b_mlast, b_mdata};
    end else begin
      stall_b <= 1'b0;
    end
  end

  int passed = 0;
  int fails = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l,
                      input logic clr, input int budget, output bit ok);
    logic r;
    ok     = 1'b0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    s_clr  = clr;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      r = sel ? s_sready : b_sready;
      @(posedge clk);
      #1;
      s_clr = 1'b0;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    s_clr  = 1'b0;
  endtask

  task automatic wait_q(input bit big, input int n);
    for (int c = 0; c < 4000; c++) begin
      if ((big ? qb.size() : qs.size()) >= n) break;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int ramp_bad(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= qb.size()) bad++;
      else if (qb[i] !== {i == n - 1, 16'(i)}) bad++;
    end
    return bad;
  endfunction

  logic [16:0] exp_short[8];
  bit ok;
  int nf;
  int acc;
  int i;
  int bad;

  initial begin
    exp_short = '{17'h000A1, 17'h000A2, 17'h000A3, 17'h000A4,
                  17'h000A5, 17'h00000, 17'h00000, 17'h10000};
    sel = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    b_clr = 1'b0; s_clr = 1'b0;
    rst_b = 1'b1; rst_s = 1'b1;
    #12;
    chk("rst_sready", b_sready, 0);
    chk("rst_mvalid", b_mvalid, 0);
    chk("rst_mlast_mdata", {b_mlast, b_mdata}, 0);
    chk("rst_err_done", {b_es, b_el, b_done}, 0);
    chk("rst_count", b_cnt, 0);
    chk("rst_small_sready", s_sready, 0);
    @(negedge clk);
    rst_b = 1'b0; rst_s = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {b_sready, s_sready}, 2'b11);

    // nominal frame
    nf = 0;
    for (int k = 0; k < 784; k++) begin
      send(16'(k), k == 783, 1'b0, 4, ok);
      if (!ok) nf++;
    end
    chk("nom_accept", nf, 0);
    wait_q(1'b1, 784);
    cycles(3);
    chk("nom_size", qb.size(), 784);
    chk("nom_data", ramp_bad(784), 0);
    chk("nom_done", done_b, 1);
    chk("nom_count", b_cnt, 1);
    chk("nom_err", {b_es, b_el}, 0);

    // backpressure: toggle, drain, stall, toggle
    qb.delete();
    bp = 1;
    nf = 0;
    for (int k = 0; k < 200; k++) begin
      send(16'(k), 1'b0, 1'b0, 50, ok);
      if (!ok) nf++;
    end
    wait_q(1'b1, 200);
    bp = 2;
    cycles(2);
    acc = 0;
    i = 200;
    ok = 1'b1;
    while (ok && i < 784) begin
      send(16'(i), i == 783, 1'b0, 40, ok);
      if (ok) begin
        acc++;
        i++;
      end
    end
    chk("bp_fill", acc, 16);
    chk("bp_ready_low", b_sready, 0);
    bp = 1;
    while (i < 784) begin
      send(16'(i), i == 783, 1'b0, 50, ok);
      if (!ok) nf++;
      i++;
    end
    chk("bp_accept", nf, 0);
    wait_q(1'b1, 784);
    bp = 0;
    cycles(3);
    chk("bp_size", qb.size(), 784);
    chk("bp_data", ramp_bad(784), 0);
    chk("bp_stall_stable", viol, 0);
    chk("bp_count", b_cnt, 2);
    chk("bp_done", done_b, 2);
    chk("bp_err", {b_es, b_el}, 0);

    // reset mid-frame
    qb.delete();
    for (int k = 0; k < 300; k++) send(16'(k), 1'b0, 1'b0, 4, ok);
    bp = 2;
    for (int k = 300; k < 310; k++) send(16'(k), 1'b0, 1'b0, 4, ok);
    cycles(1);
    #2;
    rst_b = 1'b1;
    #1;
    chk("mid_rst_mvalid", b_mvalid, 0);
    chk("mid_rst_mout", {b_mlast, b_mdata}, 0);
    chk("mid_rst_sready", b_sready, 0);
    chk("mid_rst_count", b_cnt, 0);
    bad = 0;
    foreach (qb[k]) if (qb[k][16]) bad++;
    chk("mid_rst_no_tlast", bad, 0);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready_rise", b_sready, 1);
    bp = 0;
    qb.delete();
    for (int k = 0; k < 784; k++) send(16'(k), k == 783, 1'b0, 4, ok);
    wait_q(1'b1, 784);
    cycles(20);
    chk("post_rst_size", qb.size(), 784);
    chk("post_rst_data", ramp_bad(784), 0);
    chk("post_rst_count", b_cnt, 1);

    // small instance: long frame
    sel = 1'b1;
    qs.delete();
    for (int k = 1; k <= 8; k++) send(16'(k), 1'b0, 1'b0, 4, ok);
    chk("long_drop_ready", s_sready, 1);
    acc = 0;
    for (int k = 9; k <= 11; k++) begin
      send(16'(k), k == 11, 1'b0, 1, ok);
      if (ok) acc++;
    end
    chk("long_drop_accept", acc, 3);
    wait_q(1'b0, 8);
    cycles(4);
    chk("long_size", qs.size(), 8);
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (k >= qs.size() || qs[k] !== {k == 7, 16'(k + 1)}) bad++;
    chk("long_data", bad, 0);
    chk("long_err", {s_es, s_el}, 2'b01);

    // clean frame after long
    qs.delete();
    for (int k = 0; k < 8; k++)
      send(16'h20 + 16'(k), k == 7, 1'b0, 4, ok);
    wait_q(1'b0, 8);
    cycles(3);
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (k >= qs.size() || qs[k] !== {k == 7, 16'h20 + 16'(k)}) bad++;
    chk("clean_data", bad, 0);
    chk("clean_count", s_cnt, 2);

    s_clr = 1'b1;
    cycles(1);
    s_clr = 1'b0;
    chk("clr_both", {s_es, s_el}, 0);

    // short frame
    qs.delete();
    for (int k = 1; k <= 5; k++)
      send(16'hA0 + 16'(k), k == 5, 1'b0, 4, ok);
    chk("short_pad_ready", s_sready, 0);
    wait_q(1'b0, 8);
    cycles(3);
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (k >= qs.size() || qs[k] !== exp_short[k]) bad++;
    chk("short_data", bad, 0);
    chk("short_size", qs.size(), 8);
    chk("short_err", {s_es, s_el}, 2'b10);
    chk("short_count", s_cnt, 3);

    s_clr = 1'b1;
    cycles(1);
    s_clr = 1'b0;
    chk("clr_short", s_es, 0);

    // clear coincides with the short-frame tlast: set wins
    send(16'hB1, 1'b0, 1'b0, 4, ok);
    send(16'hB2, 1'b1, 1'b1, 4, ok);
    chk("clr_vs_set", s_es, 1);
    wait_q(1'b0, 16);
    cycles(3);
    chk("clr_vs_set_count", s_cnt, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
